// File: rtl/xform_pkg.sv
// Shared definitions for the transform stream transmitter.
// Holds the default element width, lanes per beat, the number of matrix
// beats per frame and the frame sequencer state type.
package xform_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int LANES      = 4;
    localparam int MAT_BEATS  = 3;
    localparam int MAT_ELEMS  = MAT_BEATS * 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAT  = 2'd1,
        VEC  = 2'd2
    } state_t;

endpackage

// File: rtl/xform_stream_tx_if.sv
// Valid/ready stream bundle shared by the vector input and the frame output.
// Signals:
//   tdata  - beat payload, WIDTH bits
//   tvalid - source has a beat
//   tready - sink accepts the beat
//   tlast  - final beat of a frame (output stream only)
// Modports:
//   master - drives tdata/tvalid/tlast, samples tready
//   slave  - samples tdata/tvalid, drives tready
interface xform_stream_tx_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO used as the vector buffer.
// The head entry is visible on out_data whenever empty is low.
// Ports:
//   clk, rst   - clock and synchronous active-high reset (flushes contents)
//   in_data    - write data, stored when in_valid is high and not full
//   out_data   - head entry
//   out_ready  - remove the head entry (ignored when empty)
//   full/empty - occupancy flags, both registered state
module axis_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;
    logic             pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign push     = in_valid && !full;
    assign pop      = out_ready && !empty;
    assign out_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr[AW-1:0]] <= in_data;
    end

endmodule

// File: rtl/xform_stream_tx.sv
// Frame transmitter: on start, sends the 3x4 matrix as three beats followed
// by num_vec vector beats drained from an internal buffer, with tlast on the
// final vector beat.
// Ports:
//   m00_axis_aclk   - clock
//   m00_axis_areset - synchronous active-high reset
//   mat_data        - 12 signed elements, row-major, element k at k*DATA_WIDTH
//   num_vec         - vector beats in the next frame
//   start           - frame request, honoured only while idle
//   busy / done     - frame in progress / one-cycle completion pulse
//   vec             - vector input stream (slave)
//   m00_axis        - frame output stream (master)
module xform_stream_tx #(
    parameter int DATA_WIDTH = xform_pkg::DATA_WIDTH,
    parameter int LANES      = xform_pkg::LANES,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                     m00_axis_aclk,
    input  logic                     m00_axis_areset,
    input  logic [12*DATA_WIDTH-1:0] mat_data,
    input  logic [15:0]              num_vec,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    xform_stream_tx_if.slave         vec,
    xform_stream_tx_if.master        m00_axis
);
    import xform_pkg::*;

    localparam int BEAT_W = LANES * DATA_WIDTH;

    state_t                   state, state_next;
    logic [12*DATA_WIDTH-1:0] mat_reg, mat_next;
    logic [1:0]               row, row_next;
    logic [15:0]              remaining, remaining_next;
    logic                     done_next;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [BEAT_W-1:0]        fifo_data;

    axis_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_vec_fifo (
        .clk       (m00_axis_aclk),
        .rst       (m00_axis_areset),
        .in_data   (vec.tdata),
        .in_valid  (vec.tvalid),
        .out_data  (fifo_data),
        .out_ready (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The buffer accepts vectors in every state, so the next frame can be prefetched.
    assign vec.tready = !fifo_full;
    assign busy       = (state != IDLE);

    // Next-state and output decode. Matrix beats come from the latched copy so
    // that mat_data may change once a frame has begun.
    always_comb begin
        state_next      = state;
        row_next        = row;
        remaining_next  = remaining;
        mat_next        = mat_reg;
        done_next       = 1'b0;
        fifo_pop        = 1'b0;
        m00_axis.tvalid = 1'b0;
        m00_axis.tdata  = '0;
        m00_axis.tlast  = 1'b0;

        case (state)
            IDLE: begin
                if (start && (num_vec != 16'd0)) begin
                    state_next     = MAT;
                    row_next       = 2'd0;
                    remaining_next = num_vec;
                    mat_next       = mat_data;
                end
            end
            MAT: begin
                m00_axis.tvalid = 1'b1;
                m00_axis.tdata  = mat_reg[int'(row)*BEAT_W +: BEAT_W];
                if (m00_axis.tready) begin
                    if (row == 2'(MAT_BEATS - 1)) begin
                        state_next = VEC;
                        row_next   = 2'd0;
                    end else begin
                        row_next = row + 2'd1;
                    end
                end
            end
            VEC: begin
                m00_axis.tvalid = !fifo_empty;
                m00_axis.tdata  = fifo_data;
                m00_axis.tlast  = !fifo_empty && (remaining == 16'd1);
                if (!fifo_empty && m00_axis.tready) begin
                    fifo_pop = 1'b1;
                    if (remaining == 16'd1) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        remaining_next = remaining - 16'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any partial frame.
    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            state     <= IDLE;
            row       <= 2'd0;
            remaining <= 16'd0;
            mat_reg   <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            row       <= row_next;
            remaining <= remaining_next;
            mat_reg   <= mat_next;
            done      <= done_next;
        end
    end

endmodule
